sram_device_model: RTL and testbench
====================================

Name: sram_device_model

Overview:
- Cycle-accurate responder for the 16-bit external SRAM pin interface: 18-bit address, 16-bit bidirectional data, active-low byte masks and active-low CE/OE/WE strobes.
- Sits on the board side of the SRAM pins. It stands in for the physical chip in simulation and in on-FPGA loopback builds, so the memory-stage SRAM controller can be exercised end to end.
- Adds a configurable read latency, byte-lane write masking and saturating access counters for debug.

Parameters:
- ADDR_W, 18, number of address bits decoded; array depth = 2**ADDR_W words of 16 bits; legal range 8..18.
- RD_LAT, 1, cycles from read-command sample to data driven on SRAM_DQ; legal range 1..4.
- INIT_FILE, "", hex file loaded into the array at elaboration time; empty string = no load, contents X.

Ports:
- clk  input  1  system clock; all sampling on posedge.
- rst  input  1  synchronous, active-high reset.
- SRAM_DQ  inout  16  data bus; driven only during a valid read phase, Z otherwise.
- SRAM_ADDR  input  18  word address; bits above ADDR_W-1 ignored.
- SRAM_UB_N  input  1  high-byte lane enable (DQ[15:8]), active low.
- SRAM_LB_N  input  1  low-byte lane enable (DQ[7:0]), active low.
- SRAM_WE_N  input  1  write enable, active low.
- SRAM_CE_N  input  1  chip enable, active low.
- SRAM_OE_N  input  1  output enable, active low.
- rd_count  output  16  number of read commands accepted, saturating.
- wr_count  output  16  number of write commands accepted, saturating.

Behaviour:

Reset values and scope:
- rst sampled high at posedge: read pipeline valid bits = 0, rd_count = 0, wr_count = 0, SRAM_DQ = Z from the next cycle.
- Array contents are NOT cleared by rst.

Commands (sampled at each posedge clk while rst = 0):
- WRITE: CE_N=0 and WE_N=0 (OE_N ignored).
  - Commit at that edge to mem[ADDR[ADDR_W-1:0]].
  - [15:8] <= DQ[15:8] if UB_N=0; [7:0] <= DQ[7:0] if LB_N=0.
  - Both masks high: no array change, but wr_count still increments.
- READ: CE_N=0, WE_N=1, OE_N=0.
  - Launch a pipeline entry holding {valid=1, data=mem[addr], ub_n, lb_n}.
  - Array read occurs at the launch edge, after any write committed at the previous edge.
- IDLE: CE_N=1, or CE_N=0 with WE_N=1 and OE_N=1. No action; a bubble enters the pipeline.

Read pipeline:
- RD_LAT-deep shift register, one new entry every cycle, so back-to-back reads are fully pipelined at 1 word/cycle.

DQ drive rule:
- Drive DQ when the pipeline output entry is valid AND the current CE_N=0, WE_N=1, OE_N=0.
- Byte lanes whose captured mask bit is 1 drive Z.
- Entry valid but the strobe condition not met in that cycle: data is dropped, DQ = Z, no retry.

Counters:
- Increment by 1 per accepted command; hold at 16'hFFFF.

Boundary conditions:
- Address aliasing: addresses differing only above ADDR_W-1 hit the same word.
- Write then read of the same address on consecutive edges returns the new data.
- WE_N going low while reads are in flight: the write commits, in-flight entries are not driven (WE_N=1 is required to drive), and they shift out unused.
- rst asserted mid-read: flush the pipeline, release DQ at the next edge, drop the pending data.
- X/Z on control pins with CE_N=0: treat as IDLE; simulation-only $display warning.

Optional Feature:
- Macro SRAM_CONFLICT_CHK_EN.
- Defined:
  - Adds output protocol_err (1 bit, reset 0, sticky until rst).
  - Set when either of these is sampled:
    - CE_N=0 with WE_N=0 and OE_N=0 at the same edge (bus contention).
    - SRAM_ADDR changes while WE_N stays low across consecutive edges with CE_N=0 (write address slip).
  - The offending write still commits.
- Undefined: port absent; no checking logic.

Test Plan:
- Write 0xBEEF to addr 0x00010 with UB_N=LB_N=0, then read with RD_LAT=1 -> DQ=0xBEEF one cycle after the read sample; wr_count=1, rd_count=1.
- Write 0x1234 to 0x00020, then write 0xAB00 with LB_N=1, UB_N=0, then read -> 0xAB34.
- RD_LAT=3: reads of addrs 0,1,2,3 on consecutive edges (pre-loaded 0xA000..0xA003) -> DQ shows 0xA000..0xA003 on cycles 3..6 after the first launch, no gaps.
- Read launched, then rst pulsed 1 cycle before the data would appear -> DQ stays Z, counters = 0 after reset, array data intact on a re-read.
- ADDR_W=8: write 0x5555 to 0x00105, read 0x00005 -> 0x5555 (alias); 70000 reads -> rd_count=0xFFFF.
- With SRAM_CONFLICT_CHK_EN: CE_N=WE_N=OE_N=0 for one edge -> protocol_err=1 and held; cleared only by rst.

Source files
------------

// File: rtl/sram_device_model.sv
// sram_device_model: cycle-accurate stand-in for a 16-bit external SRAM chip.
// Sits on the board side of the SRAM pins. It adds a configurable read latency,
// byte-lane write masking and saturating access counters for debug.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   SRAM_DQ [15:0]      bidirectional data; driven only while a read phase is valid
//   SRAM_ADDR [17:0]    word address; bits at and above ADDR_W are ignored (aliasing)
//   SRAM_UB_N/LB_N      active-low byte lane enables (DQ[15:8] / DQ[7:0])
//   SRAM_WE_N/CE_N/OE_N active-low write / chip / output enables
//   rd_count, wr_count  saturating counts of accepted read / write commands
//   protocol_err        (only when SRAM_CONFLICT_CHK_EN is defined) sticky flag for
//                       bus contention or a write-address slip; cleared by rst
//
// Optional feature macro: SRAM_CONFLICT_CHK_EN
module sram_device_model #(
  parameter int unsigned ADDR_W    = 18,
  parameter int unsigned RD_LAT    = 1,
  parameter string       INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  inout  wire  [15:0] SRAM_DQ,
  input  logic [17:0] SRAM_ADDR,
  input  logic        SRAM_UB_N,
  input  logic        SRAM_LB_N,
  input  logic        SRAM_WE_N,
  input  logic        SRAM_CE_N,
  input  logic        SRAM_OE_N,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
`ifdef SRAM_CONFLICT_CHK_EN
  ,
  output logic        protocol_err
`endif
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
    logic              ub_n;
    logic              lb_n;
  } rd_entry_t;

  logic [DATA_W-1:0] mem [DEPTH];

  rd_entry_t         pipe_q [RD_LAT];
  rd_entry_t         pipe_d [RD_LAT];
  rd_entry_t         out_entry;
  logic [CNT_W-1:0]  rd_count_q, rd_count_d;
  logic [CNT_W-1:0]  wr_count_q, wr_count_d;
  logic [ADDR_W-1:0] addr_idx;
  logic              wr_cmd_c;
  logic              rd_cmd_c;
  logic              drive_hi_c;
  logic              drive_lo_c;
  logic              unused_addr_hi;

  assign addr_idx       = SRAM_ADDR[ADDR_W-1:0];
  assign unused_addr_hi = ^SRAM_ADDR;

  // Command decode; case equality makes X/Z on any strobe fall through to IDLE.
  always_comb begin
    wr_cmd_c = (SRAM_CE_N === 1'b0) && (SRAM_WE_N === 1'b0);
    rd_cmd_c = (SRAM_CE_N === 1'b0) && (SRAM_WE_N === 1'b1) && (SRAM_OE_N === 1'b0);
  end

  // Read pipeline shift and saturating counters.
  always_comb begin
    pipe_d[0] = '0;
    if (rd_cmd_c) begin
      pipe_d[0].valid = 1'b1;
      pipe_d[0].data  = mem[addr_idx];
      pipe_d[0].ub_n  = SRAM_UB_N;
      pipe_d[0].lb_n  = SRAM_LB_N;
    end
    for (int i = 1; i < int'(RD_LAT); i++) begin
      pipe_d[i] = pipe_q[i-1];
    end

    rd_count_d = rd_count_q;
    if (rd_cmd_c && (rd_count_q != '1)) rd_count_d = rd_count_q + CNT_W'(1);
    wr_count_d = wr_count_q;
    if (wr_cmd_c && (wr_count_q != '1)) wr_count_d = wr_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_q     <= '{default: '0};
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else begin
      pipe_q     <= pipe_d;
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
    end
  end

  // Array write with per-lane masking; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (!rst && wr_cmd_c) begin
      if (SRAM_UB_N === 1'b0) mem[addr_idx][15:8] <= SRAM_DQ[15:8];
      if (SRAM_LB_N === 1'b0) mem[addr_idx][7:0]  <= SRAM_DQ[7:0];
    end
  end

  // Pipeline output drives only while the read strobes are still asserted;
  // otherwise the data is dropped without retry.
  assign out_entry  = pipe_q[RD_LAT-1];
  assign drive_hi_c = out_entry.valid && rd_cmd_c && !out_entry.ub_n;
  assign drive_lo_c = out_entry.valid && rd_cmd_c && !out_entry.lb_n;

  assign SRAM_DQ[15:8] = drive_hi_c ? out_entry.data[15:8] : 8'hzz;
  assign SRAM_DQ[7:0]  = drive_lo_c ? out_entry.data[7:0]  : 8'hzz;

  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;

`ifdef SRAM_CONFLICT_CHK_EN
  logic        protocol_err_q, protocol_err_d;
  logic        prev_wr_q, prev_wr_d;
  logic [17:0] prev_addr_q, prev_addr_d;
  logic        contention_c;
  logic        addr_slip_c;

  // Contention: OE and WE low together. Slip: address moves during a held write.
  always_comb begin
    contention_c   = wr_cmd_c && (SRAM_OE_N === 1'b0);
    addr_slip_c    = wr_cmd_c && prev_wr_q && (SRAM_ADDR != prev_addr_q);
    protocol_err_d = protocol_err_q | contention_c | addr_slip_c;
    prev_wr_d      = wr_cmd_c;
    prev_addr_d    = SRAM_ADDR;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      protocol_err_q <= 1'b0;
      prev_wr_q      <= 1'b0;
      prev_addr_q    <= '0;
    end else begin
      protocol_err_q <= protocol_err_d;
      prev_wr_q      <= prev_wr_d;
      prev_addr_q    <= prev_addr_d;
    end
  end

  assign protocol_err = protocol_err_q;
`endif

endmodule

// File: tb/tb_sram_device_model.sv
// Bench for sram_device_model: two instances (short and long read latency,
// different address widths) share one pin stimulus stream; a memory model and
// per-instance queues of expected read data predict SRAM_DQ every cycle.
module tb_sram_device_model;

  localparam int AW_A  = 8;
  localparam int LAT_A = 1;
  localparam int AW_B  = 10;
  localparam int LAT_B = 3;

  typedef struct {
    int          due;
    logic [15:0] data;
    logic        ub_n;
    logic        lb_n;
  } rd_exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [17:0] addr;
  logic        ub_n, lb_n, we_n, ce_n, oe_n;
  logic [15:0] dq_drv;
  logic        dq_oe;
  wire  [15:0] dq_a;
  wire  [15:0] dq_b;
  logic [15:0] rd_cnt_a, wr_cnt_a, rd_cnt_b, wr_cnt_b;
`ifdef SRAM_CONFLICT_CHK_EN
  logic        perr_a, perr_b;
`endif

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  rd_exp_t     sb [2][$];
  logic [15:0] mdl [int];
  int          rdc [2];
  int          wrc [2];
  logic        perr_m      = 1'b0;
  logic        prev_wr_m   = 1'b0;
  logic [17:0] prev_addr_m = '0;

  always #5 clk = ~clk;

  assign dq_a = dq_oe ? dq_drv : 16'hzzzz;
  assign dq_b = dq_oe ? dq_drv : 16'hzzzz;

  sram_device_model #(.ADDR_W(AW_A), .RD_LAT(LAT_A)) dut_a (
    .clk(clk), .rst(rst), .SRAM_DQ(dq_a), .SRAM_ADDR(addr),
    .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .SRAM_WE_N(we_n),
    .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n),
    .rd_count(rd_cnt_a), .wr_count(wr_cnt_a)
`ifdef SRAM_CONFLICT_CHK_EN
    , .protocol_err(perr_a)
`endif
  );

  sram_device_model #(.ADDR_W(AW_B), .RD_LAT(LAT_B)) dut_b (
    .clk(clk), .rst(rst), .SRAM_DQ(dq_b), .SRAM_ADDR(addr),
    .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .SRAM_WE_N(we_n),
    .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n),
    .rd_count(rd_cnt_b), .wr_count(wr_cnt_b)
`ifdef SRAM_CONFLICT_CHK_EN
    , .protocol_err(perr_b)
`endif
  );

  function automatic int lat_of(input int i);
    return (i == 0) ? LAT_A : LAT_B;
  endfunction

  function automatic int key_of(input int i);
    int aw;
    aw = (i == 0) ? AW_A : AW_B;
    return (i << 20) + (int'(addr) & ((1 << aw) - 1));
  endfunction

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Expected bus value: our own write data, else the due read entry if the
  // read strobes are present this cycle, else released.
  task automatic check_dq(input int i, input logic [15:0] obs);
    rd_exp_t     e;
    logic [15:0] exp_v;
    exp_v = dq_oe ? dq_drv : 16'hzzzz;
    while (sb[i].size() > 0 && sb[i][0].due < cyc) void'(sb[i].pop_front());
    if (sb[i].size() > 0 && sb[i][0].due == cyc) begin
      e = sb[i].pop_front();
      if (!ce_n && we_n && !oe_n) begin
        if (!e.ub_n) exp_v[15:8] = e.data[15:8];
        if (!e.lb_n) exp_v[7:0]  = e.data[7:0];
      end
    end
    check_eq($sformatf("dq%0d@%0d", i, cyc), obs, exp_v);
  endtask

  task automatic model_edge(input int i);
    rd_exp_t     e;
    logic [15:0] w;
    int          key;
    key = key_of(i);
    if (rst) begin
      sb[i].delete();
      rdc[i] = 0;
      wrc[i] = 0;
    end else if (!ce_n && !we_n) begin
      if (!ub_n || !lb_n) begin
        w = mdl.exists(key) ? mdl[key] : 16'h0000;
        if (!ub_n) w[15:8] = dq_drv[15:8];
        if (!lb_n) w[7:0]  = dq_drv[7:0];
        mdl[key] = w;
      end
      if (wrc[i] < 65535) wrc[i]++;
    end else if (!ce_n && !oe_n) begin
      e.due  = cyc + lat_of(i) - 1;
      e.data = mdl[key];
      e.ub_n = ub_n;
      e.lb_n = lb_n;
      sb[i].push_back(e);
      if (rdc[i] < 65535) rdc[i]++;
    end
  endtask

  task automatic do_cycle(input logic r, input logic c, input logic w, input logic o,
                          input logic u, input logic l, input logic [17:0] a,
                          input logic [15:0] d);
    rst = r; ce_n = c; we_n = w; oe_n = o; ub_n = u; lb_n = l; addr = a; dq_drv = d;
    dq_oe = !r && !c && !w;
    @(negedge clk);
    check_dq(0, dq_a);
    check_dq(1, dq_b);
    @(posedge clk);
    cyc++;
    model_edge(0);
    model_edge(1);
    if (rst) begin
      perr_m    = 1'b0;
      prev_wr_m = 1'b0;
    end else begin
      if (!ce_n && !we_n && (!oe_n || (prev_wr_m && addr != prev_addr_m))) perr_m = 1'b1;
      prev_wr_m = !ce_n && !we_n;
    end
    prev_addr_m = addr;
    #1;
  endtask

  task automatic do_reset();
    do_cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 18'h0, 16'h0);
  endtask
  task automatic do_idle();
    do_cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 18'h0, 16'h0);
  endtask
  task automatic do_wr(input logic [17:0] a, input logic [15:0] d, input logic u, input logic l);
    do_cycle(1'b0, 1'b0, 1'b0, 1'b1, u, l, a, d);
  endtask
  task automatic do_rd(input logic [17:0] a);
    do_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, a, 16'h0);
  endtask

  task automatic check_counts(input string tag);
    check_eq({tag, "_rd_a"}, rd_cnt_a, 16'(rdc[0]));
    check_eq({tag, "_wr_a"}, wr_cnt_a, 16'(wrc[0]));
    check_eq({tag, "_rd_b"}, rd_cnt_b, 16'(rdc[1]));
    check_eq({tag, "_wr_b"}, wr_cnt_b, 16'(wrc[1]));
`ifdef SRAM_CONFLICT_CHK_EN
    check_eq({tag, "_perr_a"}, {15'b0, perr_a}, {15'b0, perr_m});
    check_eq({tag, "_perr_b"}, {15'b0, perr_b}, {15'b0, perr_m});
`endif
  endtask

  initial begin
    rst = 1'b1; ce_n = 1'b1; we_n = 1'b1; oe_n = 1'b1; ub_n = 1'b1; lb_n = 1'b1;
    addr = '0; dq_drv = '0; dq_oe = 1'b0;
    @(posedge clk);
    #1;
    do_reset();
    do_reset();
    check_counts("reset");

    // Full-word write then reads; long-latency entries past the burst are dropped.
    do_wr(18'h00010, 16'hBEEF, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) do_rd(18'h00010);
    for (int k = 0; k < 3; k++) do_idle();
    check_counts("basic");

    // Upper-lane-only write merges with the old low byte.
    do_wr(18'h00020, 16'h1234, 1'b0, 1'b0);
    do_wr(18'h00020, 16'hABFF, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) do_rd(18'h00020);
    do_idle();

    // Back-to-back pipelined reads.
    for (int k = 0; k < 4; k++) do_wr(18'(k), 16'hA000 + 16'(k), 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) do_rd(18'(k));
    for (int k = 0; k < 3; k++) do_rd(18'h0);
    do_idle();

    // Both masks high: counted but no array change.
    do_wr(18'h00020, 16'h7777, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) do_rd(18'h00020);
    check_counts("nomask");

    // Write while reads are in flight.
    do_rd(18'h0);
    do_rd(18'h1);
    do_wr(18'h00040, 16'h4444, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) do_rd(18'h00040);
    do_idle();

    // Reset in the middle of a read.
    do_rd(18'h00010);
    do_reset();
    check_counts("midrst");
    for (int k = 0; k < 4; k++) do_rd(18'h00010);
    do_idle();

    // Address aliasing above ADDR_W.
    do_wr(18'h00005, 16'h1111, 1'b0, 1'b0);
    do_wr(18'h00105, 16'h5555, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) do_rd(18'h00005);
    do_idle();
    check_counts("alias");

    // Protocol checks (contention, then write-address slip).
    do_reset();
    check_counts("perr0");
    do_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 18'h00050, 16'h5A5A);
    do_idle();
    do_idle();
    check_counts("perr_cont");
    do_reset();
    check_counts("perr1");
    do_wr(18'h00060, 16'h0101, 1'b0, 1'b0);
    do_wr(18'h00061, 16'h0202, 1'b0, 1'b0);
    do_idle();
    check_counts("perr_slip");
    for (int k = 0; k < 4; k++) do_rd(18'h00050);
    do_idle();

    // Counter saturation.
    do_reset();
    for (int k = 0; k < 65540; k++) do_rd(18'h00010);
    do_idle();
    check_counts("sat");
    check_eq("sat_rd_a_ffff", rd_cnt_a, 16'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
